// File: rtl/main_config_pkg.sv
// Shared configuration for the output chain: limiter settings plus the
// output fader state encoding and its default ramp/settle constants.
package main_config;

  localparam int LIMITER_DWIDTH = 24;
  localparam logic signed [LIMITER_DWIDTH-1:0] LIMITER_THRESHOLD = 24'sh700000;

  localparam int FADER_RAMP_STEP    = 64;
  localparam int FADER_RELAY_SETTLE = 128;

  typedef enum logic [2:0] {
    MUTED    = 3'd0,
    FADE_IN  = 3'd1,
    ACTIVE   = 3'd2,
    FADE_OUT = 3'd3,
    SWITCH   = 3'd4
  } fader_state_e;

endpackage

// File: rtl/output_fader_gain_ramp.sv
// Sample-rate gain ramp for the output fader: owns the fade FSM, the gain
// register, the relay drive and the relay settle counter.
module fader_gain_ramp
  import main_config::*;
#(
  parameter int GAIN_WIDTH   = 16,
  parameter int RAMP_STEP    = FADER_RAMP_STEP,
  parameter int RELAY_SETTLE = FADER_RELAY_SETTLE
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  sample_tick,
  input  logic                  init_done,
  input  logic                  mute,
  input  logic                  relay_req,
  output logic [GAIN_WIDTH-1:0] gain,
  output logic                  relay,
  output logic                  muted
);

  localparam int SW = $clog2(RELAY_SETTLE + 1);
  localparam logic [GAIN_WIDTH-1:0] UNITY       = {1'b1, {(GAIN_WIDTH-1){1'b0}}};
  localparam logic [GAIN_WIDTH-1:0] STEP        = GAIN_WIDTH'(RAMP_STEP);
  localparam logic [SW-1:0]         SETTLE_LOAD = SW'(RELAY_SETTLE);

  fader_state_e          state, state_next;
  logic [GAIN_WIDTH-1:0] gain_next, gain_up, gain_dn;
  logic [GAIN_WIDTH:0]   gain_sum;
  logic [SW-1:0]         settle, settle_next;
  logic                  relay_next, muted_next;
  logic                  mismatch, hold;

  assign mismatch = relay_req != relay;
  assign hold     = mute | ~init_done | mismatch;

  // Saturating one-step moves; the step need not divide unity.
  assign gain_sum = {1'b0, gain} + {1'b0, STEP};
  assign gain_up  = (gain_sum >= {1'b0, UNITY}) ? UNITY : gain_sum[GAIN_WIDTH-1:0];
  assign gain_dn  = (gain <= STEP) ? '0 : gain - STEP;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state  <= MUTED;
      gain   <= '0;
      settle <= '0;
      relay  <= 1'b0;
      muted  <= 1'b1;
    end else begin
      state  <= state_next;
      gain   <= gain_next;
      settle <= settle_next;
      relay  <= relay_next;
      muted  <= muted_next;
    end
  end

  // Outside SWITCH every state just ramps toward unity or zero depending on
  // hold; the state label falls out of where the gain lands.
  always_comb begin
    state_next  = state;
    gain_next   = gain;
    settle_next = settle;
    relay_next  = relay;
    if (sample_tick) begin
      if (state == SWITCH) begin
        gain_next = '0;
        if (settle <= SW'(1)) begin
          settle_next = '0;
          state_next  = MUTED;
        end else begin
          settle_next = settle - SW'(1);
        end
      end else if (hold) begin
        gain_next = gain_dn;
        if (gain_dn == '0) begin
          if (mismatch) begin
            relay_next  = relay_req;
            settle_next = SETTLE_LOAD;
            state_next  = SWITCH;
          end else begin
            state_next = MUTED;
          end
        end else begin
          state_next = FADE_OUT;
        end
      end else begin
        gain_next  = gain_up;
        state_next = (gain_up == UNITY) ? ACTIVE : FADE_IN;
      end
    end
  end

  always_comb begin
    muted_next = (gain_next == '0) && ((state_next == MUTED) || (state_next == SWITCH));
  end

endmodule

// File: rtl/output_fader.sv
// Final output conditioning: gain ramp for click-free mute/unmute and relay
// changes, followed by a two-stage multiply and fixed headroom shift.
module output_fader
  import main_config::*;
#(
  parameter int DWIDTH       = 24,
  parameter int GAIN_WIDTH   = 16,
  parameter int RAMP_STEP    = FADER_RAMP_STEP,
  parameter int ATT_SHIFT    = 3,
  parameter int RELAY_SETTLE = FADER_RELAY_SETTLE
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              sample_tick_i,
  input  logic              init_done_i,
  input  logic              mute_i,
  input  logic              relay_req_i,
  input  logic [DWIDTH-1:0] data_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              data_val_o,
  output logic              relay_o,
  output logic              muted_o
);

  localparam int PW    = DWIDTH + GAIN_WIDTH;
  localparam int SHIFT = GAIN_WIDTH - 1 + ATT_SHIFT;

  logic [GAIN_WIDTH-1:0] gain;
  logic signed [PW-1:0]  data_ext, gain_ext, prod_d, prod_q;
  logic                  prod_val;

  fader_gain_ramp #(
    .GAIN_WIDTH  (GAIN_WIDTH),
    .RAMP_STEP   (RAMP_STEP),
    .RELAY_SETTLE(RELAY_SETTLE)
  ) u_gain_ramp (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .sample_tick(sample_tick_i),
    .init_done  (init_done_i),
    .mute       (mute_i),
    .relay_req  (relay_req_i),
    .gain       (gain),
    .relay      (relay_o),
    .muted      (muted_o)
  );

  // Gain is unsigned, so it is zero-extended; the full product fits PW bits.
  assign data_ext = {{GAIN_WIDTH{data_i[DWIDTH-1]}}, data_i};
  assign gain_ext = {{DWIDTH{1'b0}}, gain};
  assign prod_d   = data_ext * gain_ext;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      prod_q   <= '0;
      prod_val <= 1'b0;
    end else begin
      prod_val <= sample_tick_i;
      if (sample_tick_i) prod_q <= prod_d;
    end
  end

  // Arithmetic shift floors toward -inf; unity gain reduces to data >>> ATT_SHIFT.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_o     <= '0;
      data_val_o <= 1'b0;
    end else begin
      data_val_o <= prod_val;
      if (prod_val) data_o <= DWIDTH'(prod_q >>> SHIFT);
    end
  end

endmodule

// File: doc/output_fader.md
Name: output_fader

Overview:
- Final output conditioning stage. Sits directly downstream of the output limiter and directly upstream of the I2S core's left-channel input.
- Replaces the fixed ×1/8 output attenuation register with a sample-rate gain ramp.
- Gives click-free start-up unmute, soft mute, and a sequenced relay change: fade out, switch the relay, wait for it to settle, fade back in.

Parameters:
DWIDTH, 24, sample width (signed two's complement)
GAIN_WIDTH, 16, unsigned gain width; unity = 2**(GAIN_WIDTH-1) = 32768
RAMP_STEP, 64, gain increment/decrement per sample tick (default full ramp = 512 samples ≈ 11.6 ms)
ATT_SHIFT, 3, fixed arithmetic right shift applied after gain (DAC headroom)
RELAY_SETTLE, 128, samples held at zero gain after a relay change

Ports:
clk_i  input  1  system clock (25 MHz)
arst_n_i  input  1  asynchronous active-low reset
sample_tick_i  input  1  one-clock pulse per sample, minimum spacing 3 clocks
init_done_i  input  1  codec configured; while 0 the output is forced muted
mute_i  input  1  soft-mute request
relay_req_i  input  1  requested relay state
data_i  input  DWIDTH  limiter output, valid on sample_tick_i
data_o  output  DWIDTH  faded, attenuated sample to the I2S core
data_val_o  output  1  one-clock pulse, data_o valid
relay_o  output  1  relay drive
muted_o  output  1  gain == 0 and state is MUTED or SWITCH

Behaviour:
- Reset is asynchronous and active-low; one clock domain only. While arst_n_i=0: state=MUTED, gain=0, relay_o=0, data_o=0, data_val_o=0, muted_o=1, settle counter=0. The product pipeline registers also clear.
- Internal hold request: hold = mute_i | !init_done_i | (relay_req_i != relay_o).
- FSM advances only on sample_tick_i, except where noted. States:
  - MUTED: gain=0.
    - If relay_req_i != relay_o: relay_o <= relay_req_i, load settle counter, go to SWITCH.
    - Else if !hold: go to FADE_IN.
  - FADE_IN: per tick gain <= min(gain+RAMP_STEP, unity).
    - Reaching unity goes to ACTIVE.
    - If hold is asserted, go to FADE_OUT from the current gain; there is no jump.
  - ACTIVE: gain=unity. If hold, go to FADE_OUT.
  - FADE_OUT: per tick gain <= max(gain-RAMP_STEP, 0).
    - On reaching 0: if relay mismatch, relay_o <= relay_req_i, load settle, go to SWITCH; otherwise go to MUTED.
    - If hold drops mid-fade, go to FADE_IN from the current gain.
  - SWITCH: gain=0; count RELAY_SETTLE ticks down.
    - relay_req_i changes during SWITCH are ignored until the count expires.
    - When the count expires, go to MUTED. MUTED re-evaluates and may start another SWITCH immediately.
- Saturation: gain never exceeds unity or goes below 0. RAMP_STEP need not divide unity.
- Datapath, 2-clock latency from sample_tick_i to data_val_o:
  - Stage 1: product = signed(data_i) × unsigned(gain), width DWIDTH+GAIN_WIDTH. It uses the gain value before this tick's FSM update.
  - Stage 2: data_o = product >>> (GAIN_WIDTH-1+ATT_SHIFT), truncated to DWIDTH, rounding toward −inf. data_val_o pulses in the same cycle.
- data_o holds its value between valid pulses.
- At unity, data_o equals data_i >>> ATT_SHIFT exactly. At gain 0, data_o = 0.
- muted_o is registered and updates with the gain.

Decomposition:
- State enum (MUTED, FADE_IN, ACTIVE, FADE_OUT, SWITCH) and the default RAMP_STEP and RELAY_SETTLE constants go in main_config, alongside LIMITER.
- One natural sub-module: fader_gain_ramp. It holds the FSM, gain register, settle counter and relay_o.
- The multiply/shift pipeline stays in output_fader.

Test Plan:
- Release reset, init_done_i=1, data_i=24'h100000 every tick:
  - 1st data_o=0.
  - Gain is 32768 after 512 ticks.
  - From tick 513 onward data_o=24'h020000 steadily.
- ACTIVE, then mute_i=1 at tick N (FADE_OUT from 32768), then mute_i=0 at tick N+256 (gain 16384):
  - Gain climbs back to unity in 256 ticks, with no discontinuity in data_o.
- ACTIVE, relay_req_i 0→1:
  - 512-tick fade to 0.
  - relay_o rises on that tick; muted_o=1 for 128 ticks.
  - 512-tick fade in, ending in ACTIVE with relay_o=1.
- Unity gain, data_i=24'h800000 → data_o=24'hF00000. data_i=24'h7FFFFF → data_o=24'h0FFFFF.
- relay_req_i toggles 1→0 during SWITCH:
  - relay_o unchanged until settle expires.
  - Then a second SWITCH, relay_o=0 and another 128 ticks, before fade in.
- Assert arst_n_i mid FADE_OUT with the clock stopped:
  - data_o=0, relay_o=0, muted_o=1 immediately.
  - After release, no data_val_o until a sample_tick_i arrives.
